// File: rtl/im_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Build option: define CHECKSUM_EN to add the trailing checksum stage.
package im_loader_pkg;

    localparam int IM_AW_DEF = 12;
    localparam int IM_DEPTH  = 1 << IM_AW_DEF;
    localparam int CNT_W_DEF = 13;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Packs an accepted byte stream into big-endian 32-bit words.
// word/word_valid are combinational so the 4th byte is usable in its own cycle.
module im_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 2'd0;
            shreg <= 24'd0;
        end else if (clear) begin
            cnt   <= 2'd0;
            shreg <= 24'd0;
        end else if (take) begin
            cnt   <= cnt + 2'd1;
            shreg <= {shreg[15:0], din};
        end
    end

    // Only the three oldest bytes need storing; the 4th is live on din.
    assign word       = {shreg, din};
    assign word_valid = take & (cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Byte-stream loader that writes packed words into instruction memory.
// Build option: CHECKSUM_EN appends a 4-byte expected-sum trailer and err flag.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int IM_AW = IM_AW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             im_we,
    output logic [31:0]      im_waddr,
    output logic [31:0]      im_wdata,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t state;
    state_t nxt;

    logic [IM_AW-1:0] word_idx;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             take;
    logic [31:0]      pk_word;
    logic             pk_valid;
    logic             unused_base;

    assign unused_base = ^{base_addr[31:IM_AW+2], base_addr[1:0]};

    assign accept = start & ((state == IDLE) | (state == DONE));
    assign take   = in_valid & in_ready;

    im_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .take       (take),
        .din        (in_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        im_we    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt = (word_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (pk_valid) begin
                    nxt = WRITE;
                end
            end
            WRITE: begin
                im_we = 1'b1;
                busy  = 1'b1;
                if (remaining == CNT_W'(1)) begin
`ifdef CHECKSUM_EN
                    nxt = CHECK;
`else
                    nxt = DONE;
`endif
                end else begin
                    nxt = RECV;
                end
            end
`ifdef CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (pk_valid) begin
                    nxt = DONE;
                end
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) begin
                    nxt = (word_count == '0) ? DONE : RECV;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // Address and data are captured with the 4th byte so they are
    // stable for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx  <= '0;
            remaining <= '0;
            im_waddr  <= 32'd0;
            im_wdata  <= 32'd0;
        end else begin
            if (accept) begin
                word_idx  <= base_addr[IM_AW+1:2];
                remaining <= word_count;
            end
            if ((state == RECV) && pk_valid) begin
                im_waddr <= {{(30-IM_AW){1'b0}}, word_idx, 2'b00};
                im_wdata <= pk_word;
            end
            if (state == WRITE) begin
                word_idx  <= word_idx + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

`ifdef CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= 32'd0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                sum <= 32'd0;
                err <= 1'b0;
            end else if (state == WRITE) begin
                sum <= sum + im_wdata;
            end else if ((state == CHECK) && pk_valid) begin
                err <= (sum != pk_word);
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: vector table plus reset/stall corner cases.
// Builds with or without CHECKSUM_EN.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [12:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_waddr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    im_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            wa.push_back(im_waddr);
            wd.push_back(im_wdata);
        end
    end

    typedef struct {
        logic [31:0] base;
        logic [63:0] bytes;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [31:0] d1;
        bit          gap;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [12:0] n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = 32'hFFFF_FFFF;
        word_count = 13'h1FFF;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            in_valid   = 1'b0;
            start      = 1'b1;
            word_count = 13'd1;
            base_addr  = 32'h0000_0100;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], 1'b0);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("done_wait", 32'(done), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({nm, "_im_we"}, 32'(im_we), 32'd0);
        chk({nm, "_im_waddr"}, im_waddr, 32'd0);
        chk({nm, "_im_wdata"}, im_wdata, 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h0000_3000, 64'h1234_5678_ABCD_EF01,
                    32'h3000, 32'h1234_5678,
                    32'h3004, 32'hABCD_EF01, 1'b0};
        vecs[1] = '{32'h0000_3FFC, 64'h0102_0304_F00D_CAFE,
                    32'h3FFC, 32'h0102_0304,
                    32'h0000, 32'hF00D_CAFE, 1'b0};
        vecs[2] = '{32'h0000_5007, 64'h0000_0000_FFFF_FFFF,
                    32'h1004, 32'h0000_0000,
                    32'h1008, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h0000_3000, 64'h1234_5678_ABCD_EF01,
                    32'h3000, 32'h1234_5678,
                    32'h3004, 32'hABCD_EF01, 1'b1};

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 32'd0;
        word_count = 13'd0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Zero-length load from IDLE.
        wa.delete();
        wd.delete();
        pulse_start(32'h100, 13'd0);
        chk("cnt0_done", 32'(done), 32'd1);
        chk("cnt0_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("cnt0_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("cnt0_writes", 32'(wa.size()), 32'd0);

        for (int v = 0; v < 4; v++) begin
            wa.delete();
            wd.delete();
            pulse_start(vecs[v].base, 13'd2);
            chk("vec_busy", 32'(busy), 32'd1);
            chk("vec_done_clr", 32'(done), 32'd0);
            for (int i = 0; i < 8; i++) begin
                send_byte(vecs[v].bytes[63-8*i -: 8], vecs[v].gap);
            end
            chk("vec_we_n1", 32'(im_we), 32'd1);
            chk("vec_waddr_n1", im_waddr, vecs[v].a1);
            chk("vec_wdata_n1", im_wdata, vecs[v].d1);
            @(posedge clk);
            #1;
            chk("vec_we_pulse", 32'(im_we), 32'd0);
`ifdef CHECKSUM_EN
            chk("vec_check_ready", 32'(in_ready), 32'd1);
            send_word(vecs[v].d0 + vecs[v].d1);
            wait_done();
`else
            chk("vec_done_n2", 32'(done), 32'd1);
`endif
            chk("vec_busy_end", 32'(busy), 32'd0);
            chk("vec_err", 32'(err), 32'd0);
            chk("vec_nwrites", 32'(wa.size()), 32'd2);
            if (wa.size() == 2) begin
                chk("vec_a0", wa[0], vecs[v].a0);
                chk("vec_d0", wd[0], vecs[v].d0);
                chk("vec_a1", wa[1], vecs[v].a1);
                chk("vec_d1", wd[1], vecs[v].d1);
            end
        end

        // Reset in the middle of a word.
        wa.delete();
        wd.delete();
        pulse_start(32'h2000, 13'd1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_writes", 32'(wa.size()), 32'd0);
        pulse_start(32'h0, 13'd1);
        send_word(32'hDEAD_BEEF);
`ifdef CHECKSUM_EN
        send_word(32'hDEAD_BEEF);
`endif
        wait_done();
        chk("reload_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("reload_addr", wa[0], 32'h0);
            chk("reload_data", wd[0], 32'hDEAD_BEEF);
        end

`ifdef CHECKSUM_EN
        pulse_start(32'h0, 13'd2);
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h3);
        wait_done();
        chk("cksum_good", 32'(err), 32'd0);
        pulse_start(32'h0, 13'd2);
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h4);
        wait_done();
        chk("cksum_bad", 32'(err), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("cksum_bad_hold", 32'(err), 32'd1);
        pulse_start(32'h0, 13'd0);
        chk("cksum_clr", 32'(err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
